// File: rtl/bcd_seq_converter.sv
// -----------------------------------------------------------------------------
// bcd_seq_converter
//
// Multi-cycle binary-to-BCD converter. A shift-and-add-3 (double-dabble)
// datapath processes one operand bit per clock under a three-state FSM.
// Results appear on registered digit outputs that change only when done
// pulses. A registered leading-zero mask is provided for the display
// multiplexer.
//
// Ports:
//   clk                rising-edge clock
//   rst                asynchronous, active-low reset
//   start              conversion request, accepted in IDLE or DONE
//   A[DW-1:0]          unsigned operand, captured on the accepting edge
//   busy               high while the shift sequence runs
//   done               one-cycle pulse, digit outputs just updated
//   ONES..TEN_THOUSANDS  registered BCD digits (4 bits each)
//   HUNDRED_THOUSANDS  registered MSD, always 0 for a 16-bit operand
//   digit_en[5:0]      leading-zero mask, bit0=ONES .. bit5=HUNDRED_THOUSANDS
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module bcd_seq_converter #(
    parameter int DW = 16   // only 16 is supported (counter/digit count sized for it)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] A,
    output logic          busy,
    output logic          done,
    output logic [3:0]    ONES,
    output logic [3:0]    TENS,
    output logic [3:0]    HUNDREDS,
    output logic [3:0]    THOUSANDS,
    output logic [3:0]    TEN_THOUSANDS,
    output logic          HUNDRED_THOUSANDS,
    output logic [5:0]    digit_en
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_SHIFT = 4'd15;

    state_t        r_state;
    state_t        w_state_next;
    logic          w_load;
    logic          w_shift;
    logic          w_finish;

    logic [DW-1:0] r_bin_sr;
    logic [19:0]   r_bcd_sr;
    logic [3:0]    r_cnt;

    logic [19:0]   w_bcd_adj;
    logic [19:0]   w_bcd_shifted;
    logic [DW-1:0] w_bin_shifted;
    logic [4:0]    w_nz;
    logic [5:0]    w_digit_en;

    logic          r_busy;
    logic          r_done;
    logic [3:0]    r_ones;
    logic [3:0]    r_tens;
    logic [3:0]    r_hundreds;
    logic [3:0]    r_thousands;
    logic [3:0]    r_ten_thousands;
    logic [5:0]    r_digit_en;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and control decode
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // start is deliberately not looked at here: requests during
                // a conversion are dropped, not queued.
                w_shift = 1'b1;
                if (r_cnt == LAST_SHIFT) begin
                    w_finish     = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // Accepting start here gives back-to-back conversions with
                // no idle cycle in between.
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = S_SHIFT;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Double-dabble step: add-3 correction on the pre-shift value, then
    // shift {bcd, bin} left by one.
    // ------------------------------------------------------------------
    always_comb begin
        w_bcd_adj = r_bcd_sr;
        for (int i = 0; i < 5; i++) begin
            if (r_bcd_sr[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd_sr[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_bcd_shifted = {w_bcd_adj[18:0], r_bin_sr[DW-1]};
    assign w_bin_shifted = {r_bin_sr[DW-2:0], 1'b0};

    // Leading-zero mask from the post-shift value: a digit is shown when it
    // or any more significant digit is nonzero; ONES is always shown.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            w_nz[i] = |w_bcd_shifted[4*i +: 4];
        end
    end

    assign w_digit_en = {1'b0,
                         w_nz[4],
                         |w_nz[4:3],
                         |w_nz[4:2],
                         |w_nz[4:1],
                         1'b1};

    // ------------------------------------------------------------------
    // Datapath shift registers and counter
    // ------------------------------------------------------------------
    // NOTE: the datapath registers are reset as well, so an aborted
    // conversion leaves nothing behind and the reset state is fully defined.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bin_sr <= '0;
            r_bcd_sr <= '0;
            r_cnt    <= '0;
        end else if (w_load) begin
            r_bin_sr <= A;
            r_bcd_sr <= '0;
            r_cnt    <= '0;
        end else if (w_shift) begin
            r_bin_sr <= w_bin_shifted;
            r_bcd_sr <= w_bcd_shifted;
            r_cnt    <= r_cnt + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Output registers: loaded only on the final shift, so intermediate
    // values never reach the display path.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ones          <= '0;
            r_tens          <= '0;
            r_hundreds      <= '0;
            r_thousands     <= '0;
            r_ten_thousands <= '0;
            r_digit_en      <= 6'b000001;
        end else if (w_finish) begin
            r_ones          <= w_bcd_shifted[3:0];
            r_tens          <= w_bcd_shifted[7:4];
            r_hundreds      <= w_bcd_shifted[11:8];
            r_thousands     <= w_bcd_shifted[15:12];
            r_ten_thousands <= w_bcd_shifted[19:16];
            r_digit_en      <= w_digit_en;
        end
    end

    // busy/done are registered decodes of the next state, so they are
    // aligned with r_state and free of decode glitches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_next == S_SHIFT);
            r_done <= (w_state_next == S_DONE);
        end
    end

    assign busy              = r_busy;
    assign done              = r_done;
    assign ONES              = r_ones;
    assign TENS              = r_tens;
    assign HUNDREDS          = r_hundreds;
    assign THOUSANDS         = r_thousands;
    assign TEN_THOUSANDS     = r_ten_thousands;
    assign HUNDRED_THOUSANDS = 1'b0;
    assign digit_en          = r_digit_en;

endmodule
